regfile_mp: RTL and testbench

Parametrised multi-ported register file with a pending-write scoreboard, replacing the fixed 32×32 read-mux datapath in the pipelined CPU. It provides NUM_RD registered read ports and one write port, hardwires register 0 to zero, forwards same-cycle writes to readers, and tracks which registers have an in-flight writer so the hazard unit can stall. It sits in the decode stage: decode issues read requests and claims, and writeback drives the write port.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_read_port.sv | 54 +++++
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    localparam int ZERO_REG = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: storage mux, same-cycle write bypass, scoreboard lookup.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [NUM_REGS*DATA_W-1:0] mem,
    input  logic [NUM_REGS-1:0]        busy_vec,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       valid,
    output logic [DATA_W-1:0]          data,
    output logic                       busy
);

    logic              hit;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;

    // A same-cycle write to the addressed register is the newest value and clears
    // its pending state; a same-cycle claim belongs to a younger instruction, so
    // the scoreboard is sampled before this edge's updates.
    always_comb begin
        hit   = wr_en && (wr_addr == addr) && (addr != ADDR_W'(ZERO_REG));
        rdata = mem[int'(addr)*DATA_W +: DATA_W];
        rbusy = busy_vec[addr];
        if (hit) begin
            rdata = wr_data;
            rbusy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            busy  <= 1'b0;
        end else begin
            valid <= req;
            busy  <= req ? rbusy : 1'b0;
            if (req) begin
                data <= rdata;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with r0 hardwired to zero and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [NUM_REGS*DATA_W-1:0] mem_q;
    logic                       wr_ok;
    logic                       claim_ok;

    assign wr_ok    = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
    assign claim_ok = claim_en && (claim_addr != ADDR_W'(ZERO_REG));

    // Slot 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else if (wr_ok) begin
            mem_q[int'(wr_addr)*DATA_W +: DATA_W] <= wr_data;
        end
    end

    // Claim is applied after the write clear so a colliding claim leaves the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec <= '0;
        end else begin
            if (wr_ok) begin
                busy_vec[wr_addr] <= 1'b0;
            end
            if (claim_ok) begin
                busy_vec[claim_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ADDR_W  (ADDR_W)
        ) u_port (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (rd_req[p]),
            .addr    (rd_addr[p*ADDR_W +: ADDR_W]),
            .mem     (mem_q),
            .busy_vec(busy_vec),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .valid   (rd_valid[p]),
            .data    (rd_data[p*DATA_W +: DATA_W]),
            .busy    (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp with hand-written reset sequences.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic            clk;
    logic            reset_n;
    logic [1:0]      rd_req;
    logic [9:0]      rd_addr;
    logic [1:0]      rd_valid;
    logic [63:0]     rd_data;
    logic [1:0]      rd_busy;
    logic            wr_en;
    reg_addr_t       wr_addr;
    reg_data_t       wr_data;
    logic            claim_en;
    reg_addr_t       claim_addr;
    logic [31:0]     busy_vec;

    int total;
    int bad;

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .claim_en  (claim_en),
        .claim_addr(claim_addr),
        .busy_vec  (busy_vec)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      wr_en;
        reg_addr_t wr_addr;
        reg_data_t wr_data;
        logic      claim_en;
        reg_addr_t claim_addr;
        logic [1:0] req;
        reg_addr_t a0;
        reg_addr_t a1;
        logic [1:0] exp_valid;
        logic [1:0] chk_data;
        reg_data_t exp_d0;
        reg_data_t exp_d1;
        logic [1:0] exp_busy;
        logic [31:0] exp_bvec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rd_req     = '0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic add(input logic we, input int wa, input logic [31:0] wd,
                       input logic ce, input int ca,
                       input logic [1:0] req, input int a0, input int a1,
                       input logic [1:0] ev, input logic [1:0] cd,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] eb, input logic [31:0] bv);
        vec_t v;
        v.wr_en = we; v.wr_addr = reg_addr_t'(wa); v.wr_data = wd;
        v.claim_en = ce; v.claim_addr = reg_addr_t'(ca);
        v.req = req; v.a0 = reg_addr_t'(a0); v.a1 = reg_addr_t'(a1);
        v.exp_valid = ev; v.chk_data = cd; v.exp_d0 = d0; v.exp_d1 = d1;
        v.exp_busy = eb; v.exp_bvec = bv;
        vecs.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        drive_idle();

        //  we wa wdata        ce ca  req a0 a1  ev    cd    d0           d1           eb    bvec
        add(1, 5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0,            0,            2'b00, 32'h0);
        add(0, 0, 0,            0, 0, 2'b01, 5, 0, 2'b01, 2'b01, 32'hDEADBEEF, 0,            2'b00, 32'h0);
        add(1, 0, 32'h1234,     0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0,            0,            2'b00, 32'h0);
        add(0, 0, 0,            1, 0, 2'b01, 0, 0, 2'b01, 2'b01, 0,            0,            2'b00, 32'h0);
        add(1, 7, 32'hA5A5A5A5, 0, 0, 2'b11, 7, 7, 2'b11, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0);
        add(0, 0, 0,            1, 3, 2'b00, 0, 0, 2'b00, 2'b00, 0,            0,            2'b00, 32'h8);
        add(0, 0, 0,            0, 0, 2'b01, 3, 0, 2'b01, 2'b01, 0,            0,            2'b01, 32'h8);
        add(1, 3, 32'h55,       0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0,            0,            2'b00, 32'h0);
        add(0, 0, 0,            0, 0, 2'b10, 0, 3, 2'b10, 2'b10, 0,            32'h55,       2'b00, 32'h0);
        add(1, 9, 32'h77,       1, 9, 2'b00, 0, 0, 2'b00, 2'b00, 0,            0,            2'b00, 32'h200);
        add(0, 0, 0,            0, 0, 2'b11, 9, 7, 2'b11, 2'b11, 32'h77,       32'hA5A5A5A5, 2'b01, 32'h200);
        add(1, 11, 32'hCAFE,    1, 11, 2'b11, 11, 11, 2'b11, 2'b11, 32'hCAFE,  32'hCAFE,     2'b00, 32'hA00);
        add(0, 0, 0,            0, 0, 2'b00, 0, 0, 2'b00, 2'b11, 32'hCAFE,     32'hCAFE,     2'b00, 32'hA00);
        add(1, 9, 32'h99,       0, 0, 2'b10, 0, 5, 2'b10, 2'b10, 0,            32'hDEADBEEF, 2'b00, 32'h800);
        add(0, 0, 0,            0, 0, 2'b11, 9, 11, 2'b11, 2'b11, 32'h99,      32'hCAFE,     2'b10, 32'h800);

        #12;
        check("reset_valid", 64'(rd_valid), 64'h0);
        check("reset_data",  rd_data, 64'h0);
        check("reset_busy",  64'(rd_busy), 64'h0);
        check("reset_bvec",  64'(busy_vec), 64'h0);

        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            wr_en      = vecs[i].wr_en;
            wr_addr    = vecs[i].wr_addr;
            wr_data    = vecs[i].wr_data;
            claim_en   = vecs[i].claim_en;
            claim_addr = vecs[i].claim_addr;
            rd_req     = vecs[i].req;
            rd_addr    = {vecs[i].a1, vecs[i].a0};
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_bvec", i), 64'(busy_vec), 64'(vecs[i].exp_bvec));
            if (vecs[i].exp_valid[0])
                check($sformatf("v%0d_busy0", i), 64'(rd_busy[0]), 64'(vecs[i].exp_busy[0]));
            if (vecs[i].exp_valid[1])
                check($sformatf("v%0d_busy1", i), 64'(rd_busy[1]), 64'(vecs[i].exp_busy[1]));
            if (vecs[i].chk_data[0])
                check($sformatf("v%0d_data0", i), 64'(rd_data[31:0]), 64'(vecs[i].exp_d0));
            if (vecs[i].chk_data[1])
                check($sformatf("v%0d_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].exp_d1));
        end

        // Reset mid-operation: reads in flight, a register claimed.
        @(negedge clk);
        drive_idle();
        rd_req     = 2'b11;
        rd_addr    = {5'd7, 5'd5};
        claim_en   = 1'b1;
        claim_addr = 5'd3;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(rd_valid), 64'h3);
        check("pre_rst_bvec", 64'(busy_vec), 64'h808);
        claim_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rd_valid), 64'h0);
        check("mid_rst_data", rd_data, 64'h0);
        check("mid_rst_busy", 64'(rd_busy), 64'h0);
        check("mid_rst_bvec", 64'(busy_vec), 64'h0);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_valid%0d", k), 64'(rd_valid), 64'h0);
        end

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            rd_req  = 2'b11;
            rd_addr = {reg_addr_t'(2*r+1), reg_addr_t'(2*r)};
            @(posedge clk);
            #1;
            check($sformatf("clr_valid_r%0d", 2*r), 64'(rd_valid), 64'h3);
            check($sformatf("clr_data_r%0d", 2*r), rd_data, 64'h0);
            check($sformatf("clr_busy_r%0d", 2*r), 64'(rd_busy), 64'h0);
        end
        check("final_bvec", 64'(busy_vec), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
